// File: rtl/stable_value_pkg.sv
// stable_value_pkg
// Shared definitions for the stable value driver:
//   - state_e    : 2-bit FSM state encoding (IDLE, GAP, HOLD); 2'b11 is unused
//   - cnt_width(): width of the shared phase counter, sized so that the
//                  longest phase length minus one fits
package stable_value_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GAP  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  function automatic int cnt_width(input int hold_n, input int gap_n);
    int m;
    m = (hold_n > gap_n) ? hold_n : gap_n;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sample_counter.sv
// sample_counter
// Loadable down counter with a zero flag. One instance is shared by the GAP
// and HOLD phases; it saturates at zero instead of wrapping.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset (count -> 0)
//   i_load     : load i_load_val on this edge (takes priority over counting)
//   i_load_val : value loaded, normally phase length minus one
//   o_zero     : count currently reads zero
module sample_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset)                r_count <= '0;
    else if (i_load)          r_count <= i_load_val;
    else if (r_count != '0)   r_count <= r_count - 1'b1;
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/stable_value_driver.sv
// stable_value_driver
// Accepts one word over a load/ready handshake and drives it onto the pins,
// holding it for HOLD_SAMPLES cycles so a debouncing receiver sees a settled
// value. Build option STABLE_VALUE_DRIVER_GAP_EN inserts GAP_SAMPLES cycles of
// IDLE_VALUE before every word so the receiver re-arms on repeated words.
// Ports:
//   samplingClock   : sole clock, rising edge
//   reset           : synchronous active-high reset, aborts any word in flight
//   value           : word to transmit, sampled only on an accepting edge
//   load            : producer request; accepted when load && ready
//   ready           : idle and able to accept a word
//   drivenValue_reg : registered pin value
//   isDriving       : word is inside its hold window
//   done            : one-cycle pulse when HOLD returns to IDLE
module stable_value_driver
  import stable_value_pkg::*;
#(
  parameter int              SIZE         = 1,
  parameter int              HOLD_SAMPLES = 4,
  parameter int              GAP_SAMPLES  = 2,
  parameter logic [SIZE-1:0] IDLE_VALUE   = '0
) (
  input  logic            samplingClock,
  input  logic            reset,
  input  logic [SIZE-1:0] value,
  input  logic            load,
  output logic            ready,
  output logic [SIZE-1:0] drivenValue_reg,
  output logic            isDriving,
  output logic            done
);

  localparam int           CW      = cnt_width(HOLD_SAMPLES, GAP_SAMPLES);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_SAMPLES - 1);
`ifdef STABLE_VALUE_DRIVER_GAP_EN
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_SAMPLES - 1);
`endif

  state_e          r_state, w_next;
  logic            w_cnt_load, w_cnt_zero;
  logic [CW-1:0]   w_cnt_val;
  logic            w_accept, w_hold_entry, w_hold_exit;
  logic            w_ready, w_is_driving;
  logic [SIZE-1:0] r_drive;
  logic            r_done;

  sample_counter #(.W(CW)) u_cnt (
    .clk        (samplingClock),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge samplingClock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_val    = '0;
    w_accept     = 1'b0;
    w_hold_entry = 1'b0;
    w_hold_exit  = 1'b0;
    w_ready      = 1'b0;
    w_is_driving = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (load) begin
          w_accept   = 1'b1;
          w_cnt_load = 1'b1;
`ifdef STABLE_VALUE_DRIVER_GAP_EN
          w_next     = ST_GAP;
          w_cnt_val  = GAP_LD;
`else
          w_next       = ST_HOLD;
          w_cnt_val    = HOLD_LD;
          w_hold_entry = 1'b1;
`endif
        end
      end
`ifdef STABLE_VALUE_DRIVER_GAP_EN
      ST_GAP: begin
        if (w_cnt_zero) begin
          w_next       = ST_HOLD;
          w_cnt_load   = 1'b1;
          w_cnt_val    = HOLD_LD;
          w_hold_entry = 1'b1;
        end
      end
`endif
      ST_HOLD: begin
        w_is_driving = 1'b1;
        if (w_cnt_zero) begin
          w_next      = ST_IDLE;
          w_hold_exit = 1'b1;
        end
      end
      // 2'b11, and GAP when the gap phase is not built, fall back to IDLE
      default: w_next = ST_IDLE;
    endcase
  end

`ifdef STABLE_VALUE_DRIVER_GAP_EN
  logic [SIZE-1:0] r_pending;

  always_ff @(posedge samplingClock) begin
    if (reset) begin
      r_pending <= IDLE_VALUE;
      r_drive   <= IDLE_VALUE;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_hold_exit;
      if (w_accept)     r_pending <= value;
      // separator starts on the accepting edge, word lands on HOLD entry
      if (w_accept)     r_drive   <= IDLE_VALUE;
      if (w_hold_entry) r_drive   <= r_pending;
    end
  end
`else
  // Accept and HOLD entry share one edge, so the pin register itself is the
  // only place the word needs to be captured.
  always_ff @(posedge samplingClock) begin
    if (reset) begin
      r_drive <= IDLE_VALUE;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_hold_exit;
      if (w_hold_entry) r_drive <= value;
    end
  end
`endif

  assign ready           = w_ready;
  assign isDriving       = w_is_driving;
  assign drivenValue_reg = r_drive;
  assign done            = r_done;

endmodule

// File: tb/tb_stable_value_driver.sv
module tb_stable_value_driver;
  localparam int SIZE = 4;
  localparam int H    = 4;
  localparam int G    = 2;
  localparam logic [SIZE-1:0] IDLE = 4'h0;
`ifdef STABLE_VALUE_DRIVER_GAP_EN
  localparam int GE = G;
`else
  localparam int GE = 0;
`endif
  localparam int BUSY = GE + H;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            load = 1'b0;
  logic [SIZE-1:0] value = '0;
  logic            ready, isDriving, done;
  logic [SIZE-1:0] drivenValue_reg;

  stable_value_driver #(
    .SIZE(SIZE), .HOLD_SAMPLES(H), .GAP_SAMPLES(G), .IDLE_VALUE(IDLE)
  ) dut (
    .samplingClock   (clk),
    .reset           (reset),
    .value           (value),
    .load            (load),
    .ready           (ready),
    .drivenValue_reg (drivenValue_reg),
    .isDriving       (isDriving),
    .done            (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0;

  // reference model: time since the last accepted word decides everything
  bit              m_active = 0, m_acc = 0;
  int              m_k = 0;
  logic [SIZE-1:0] m_word = '0, m_base = IDLE;
  logic [SIZE-1:0] exp_pins = IDLE;
  logic            exp_ready = 1'b1, exp_drv = 1'b0, exp_done = 1'b0;

  // far-end receiver: reports a value once it has been seen H samples in a row
  logic [SIZE-1:0] det_prev = 'x;
  int              det_run = 0;
  logic [SIZE-1:0] det_q[$];

  task automatic step(input logic r, input logic ld, input logic [SIZE-1:0] v);
    int d;
    reset = r; load = ld; value = v;
    m_acc = ld && exp_ready && !r;
    @(posedge clk); #1;
    cyc++;
    if (r) begin
      m_active = 0; m_base = IDLE;
    end else if (m_acc) begin
      m_active = 1; m_k = cyc; m_word = v;
    end
    exp_pins = m_base; exp_ready = 1'b1; exp_drv = 1'b0; exp_done = 1'b0;
    if (m_active) begin
      d = cyc - m_k;
      if (d < GE) begin
        exp_pins = IDLE; exp_ready = 1'b0;
      end else if (d < BUSY) begin
        exp_pins = m_word; exp_ready = 1'b0; exp_drv = 1'b1;
      end else begin
        exp_pins = m_word; exp_done = 1'b1; m_base = m_word; m_active = 0;
      end
    end
    if (drivenValue_reg === det_prev) det_run++;
    else begin det_run = 1; det_prev = drivenValue_reg; end
    if (det_run == H) det_q.push_back(drivenValue_reg);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) step(1'b0, 1'b0, '0);
      n_vec++; if (drivenValue_reg !== IDLE) begin n_err++; $display("FAIL reset_pins cyc=%0d got %h want %h", cyc, drivenValue_reg, IDLE); end
      n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready cyc=%0d got %b want 1", cyc, ready); end
      n_vec++; if (isDriving !== 1'b0) begin n_err++; $display("FAIL reset_isDriving cyc=%0d got %b want 0", cyc, isDriving); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done cyc=%0d got %b want 0", cyc, done); end
    end
  endtask

  task automatic test_single_word();
    int low = 0, pulses = 0;
    for (int i = 0; i < BUSY + 3; i++) begin
      step(1'b0, i == 0, 4'hA);
      if (ready === 1'b0) low++;
      if (done === 1'b1) pulses++;
      n_vec++; if (drivenValue_reg !== exp_pins) begin n_err++; $display("FAIL single_pins cyc=%0d got %h want %h", cyc, drivenValue_reg, exp_pins); end
      n_vec++; if (ready !== exp_ready) begin n_err++; $display("FAIL single_ready cyc=%0d got %b want %b", cyc, ready, exp_ready); end
      n_vec++; if (isDriving !== exp_drv) begin n_err++; $display("FAIL single_isDriving cyc=%0d got %b want %b", cyc, isDriving, exp_drv); end
      n_vec++; if (done !== exp_done) begin n_err++; $display("FAIL single_done cyc=%0d got %b want %b", cyc, done, exp_done); end
    end
    n_vec++; if (low != BUSY) begin n_err++; $display("FAIL single_ready_low_cycles got %0d want %0d", low, BUSY); end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL single_done_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_back_to_back();
    logic [SIZE-1:0] want;
    int dones = 0;
    for (int i = 0; i < 2 * (BUSY + 1); i++) begin
      step(1'b0, 1'b1, 4'h5);
      want = ((i % (BUSY + 1)) < GE) ? IDLE : 4'h5;
      if (done === 1'b1) dones++;
      n_vec++; if (drivenValue_reg !== want) begin n_err++; $display("FAIL b2b_pin_seq i=%0d got %h want %h", i, drivenValue_reg, want); end
      n_vec++; if (ready !== exp_ready) begin n_err++; $display("FAIL b2b_ready cyc=%0d got %b want %b", cyc, ready, exp_ready); end
      n_vec++; if (isDriving !== exp_drv) begin n_err++; $display("FAIL b2b_isDriving cyc=%0d got %b want %b", cyc, isDriving, exp_drv); end
      n_vec++; if (done !== exp_done) begin n_err++; $display("FAIL b2b_done cyc=%0d got %b want %b", cyc, done, exp_done); end
    end
    n_vec++; if (dones != 2) begin n_err++; $display("FAIL b2b_word_count got %0d want 2", dones); end
  endtask

  task automatic test_busy_load_ignored();
    for (int i = 0; i < BUSY + 3; i++) begin
      if (i == 0) step(1'b0, 1'b1, 4'h3);
      else        step(1'b0, (i == 1 || i == 2), 4'hF);
      n_vec++; if (drivenValue_reg === 4'hF) begin n_err++; $display("FAIL busy_F_on_pins cyc=%0d got %h", cyc, drivenValue_reg); end
      n_vec++; if (drivenValue_reg !== exp_pins) begin n_err++; $display("FAIL busy_pins cyc=%0d got %h want %h", cyc, drivenValue_reg, exp_pins); end
      n_vec++; if (ready !== exp_ready) begin n_err++; $display("FAIL busy_ready cyc=%0d got %b want %b", cyc, ready, exp_ready); end
      n_vec++; if (isDriving !== exp_drv) begin n_err++; $display("FAIL busy_isDriving cyc=%0d got %b want %b", cyc, isDriving, exp_drv); end
      n_vec++; if (done !== exp_done) begin n_err++; $display("FAIL busy_done cyc=%0d got %b want %b", cyc, done, exp_done); end
    end
  endtask

  task automatic test_reset_mid_hold();
    step(1'b0, 1'b1, 4'h7);
    for (int i = 0; i < GE + 1; i++) step(1'b0, 1'b0, '0);
    // now in the second HOLD cycle: reset and a new load on the same edge
    step(1'b1, 1'b1, 4'h9);
    n_vec++; if (drivenValue_reg !== IDLE) begin n_err++; $display("FAIL rst_hold_pins got %h want %h", drivenValue_reg, IDLE); end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_hold_ready got %b want 1", ready); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_hold_done got %b want 0", done); end
    n_vec++; if (isDriving !== 1'b0) begin n_err++; $display("FAIL rst_hold_isDriving got %b want 0", isDriving); end
    for (int i = 0; i < BUSY + 2; i++) begin
      step(1'b0, 1'b0, '0);
      n_vec++; if (drivenValue_reg !== IDLE || done !== 1'b0 || ready !== 1'b1) begin
        n_err++; $display("FAIL rst_hold_dropped cyc=%0d pins=%h done=%b ready=%b want %h/0/1", cyc, drivenValue_reg, done, ready, IDLE);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), SIZE'($urandom));
      n_vec++; if (drivenValue_reg !== exp_pins) begin n_err++; $display("FAIL rnd_pins cyc=%0d got %h want %h", cyc, drivenValue_reg, exp_pins); end
      n_vec++; if (ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready cyc=%0d got %b want %b", cyc, ready, exp_ready); end
      n_vec++; if (isDriving !== exp_drv) begin n_err++; $display("FAIL rnd_isDriving cyc=%0d got %b want %b", cyc, isDriving, exp_drv); end
      n_vec++; if (done !== exp_done) begin n_err++; $display("FAIL rnd_done cyc=%0d got %b want %b", cyc, done, exp_done); end
    end
  endtask

  task automatic test_loopback();
    logic [SIZE-1:0] words[3];
    int idx = 0, budget = 0;
    words[0] = 4'h1; words[1] = 4'h0; words[2] = 4'h1;
    step(1'b1, 1'b0, '0);
    det_q.delete(); det_run = 0; det_prev = 'x;
    while (idx < 3 && budget < 200) begin
      step(1'b0, 1'b1, words[idx]);
      if (m_acc) idx++;
      budget++;
    end
    n_vec++; if (idx != 3) begin n_err++; $display("FAIL loop_accept_timeout accepted %0d want 3", idx); end
    for (int i = 0; i < BUSY + 4; i++) step(1'b0, 1'b0, '0);
    n_vec++;
    if (det_q.size() != 3) begin
      n_err++; $display("FAIL loop_report_count got %0d want 3", det_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++; if (det_q[i] !== words[i]) begin n_err++; $display("FAIL loop_report_%0d got %h want %h", i, det_q[i], words[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_busy_load_ignored();
    test_reset_mid_hold();
    test_random();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
